// File: rtl/seven_segment_hex_decoder_pkg.sv
// Shared constants for the 7-segment hex decoder: digit patterns,
// blank pattern, segment bit order and the filter state type.
package seven_segment_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Segment n of the display sits at bus bit (SEG_BIT_SEG0 - n),
    // i.e. segment 0 is the MSB. Shared with the mapping direction.
    localparam int SEG_BIT_SEG0 = SEG_W - 1;

    // Active-low patterns, MSB = segment 0.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0011000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic {
        S_SETTLING,
        S_LOCKED
    } state_t;

endpackage

// File: rtl/seven_segment_hex_decoder_if.sv
// Segment sample input plus decoded-digit valid/ready output.
// master: the decoder; slave: sampler/consumer side.
interface seven_segment_hex_decoder_if;
    import seven_segment_pkg::*;

    logic       I_STROBE;
    seg_t       I_7_SEGMENT;
    logic       O_VALID;
    logic       I_READY;
    logic [3:0] O_VALUE;
    logic       O_ERROR;
    logic       O_OVERRUN;

    modport master (
        input  I_STROBE,
        input  I_7_SEGMENT,
        input  I_READY,
        output O_VALID,
        output O_VALUE,
        output O_ERROR,
        output O_OVERRUN
    );

    modport slave (
        output I_STROBE,
        output I_7_SEGMENT,
        output I_READY,
        input  O_VALID,
        input  O_VALUE,
        input  O_ERROR,
        input  O_OVERRUN
    );
endinterface

// File: rtl/seven_segment_hex_unmapping.sv
// Combinational inverse of the hex-to-7-segment table.
// Ports: pattern in; hit/value out for a digit, blank for all-off.
module seven_segment_hex_unmapping
    import seven_segment_pkg::*;
(
    input  seg_t       pattern,
    output logic       hit,
    output logic [3:0] value,
    output logic       blank
);

    always_comb begin
        hit   = 1'b1;
        value = 4'h0;
        blank = (pattern == SEG_BLANK);
        case (pattern)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_hex_decoder.sv
// Stability filter, decode and one-entry output buffer for a sampled
// 7-segment bus. Ports: I_CLK, I_RESET (sync, high), bus (master).
module seven_segment_hex_decoder
    import seven_segment_pkg::*;
#(
    parameter int P_STABLE_COUNT = 4
) (
    input logic                      I_CLK,
    input logic                      I_RESET,
    seven_segment_hex_decoder_if.master bus
);

    localparam int CW = $clog2(P_STABLE_COUNT + 1);
    localparam logic [CW-1:0] C_MAX = CW'(P_STABLE_COUNT);

    state_t        state, state_nxt;
    seg_t          cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;

    logic          dec_hit;
    logic [3:0]    dec_value;
    logic          dec_blank;
    logic          emit;

    logic          valid_q;
    logic [3:0]    value_q;
    logic          error_q;
    logic          overrun_q;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        if (bus.I_STROBE) begin
            if (bus.I_7_SEGMENT != cand) begin
                cand_nxt  = bus.I_7_SEGMENT;
                cnt_nxt   = CW'(1);
                state_nxt = S_SETTLING;
            end else if (state == S_SETTLING) begin
                cnt_nxt = (cnt >= C_MAX) ? C_MAX : cnt + CW'(1);
            end
            if (state_nxt == S_SETTLING && cnt_nxt == C_MAX) begin
                accept    = 1'b1;
                state_nxt = S_LOCKED;
            end
        end
    end

    // Decode the value the candidate register is about to hold, so a
    // pattern accepted on its loading strobe is decoded in time.
    seven_segment_hex_unmapping u_unmap (
        .pattern (cand_nxt),
        .hit     (dec_hit),
        .value   (dec_value),
        .blank   (dec_blank)
    );

    assign emit = accept && !dec_blank;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state <= S_LOCKED;
            cand  <= SEG_BLANK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            valid_q   <= 1'b0;
            value_q   <= 4'h0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (emit) begin
            // A completing handshake frees the slot in the same cycle.
            if (!valid_q || bus.I_READY) begin
                valid_q <= 1'b1;
                value_q <= dec_hit ? dec_value : 4'h0;
                error_q <= !dec_hit;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && bus.I_READY) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.O_VALID   = valid_q;
    assign bus.O_VALUE   = value_q;
    assign bus.O_ERROR   = error_q;
    assign bus.O_OVERRUN = overrun_q;

endmodule

// File: tb/tb_seven_segment_hex_decoder.sv
// Directed bench: P_STABLE_COUNT=4 and P_STABLE_COUNT=1 instances.
// Inputs change #1 after the rising edge; outputs checked there too.
module tb_seven_segment_hex_decoder;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seven_segment_hex_decoder_if ifa ();
    seven_segment_hex_decoder_if ifb ();

    seven_segment_hex_decoder #(.P_STABLE_COUNT(4)) dut_a (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (ifa.master)
    );

    seven_segment_hex_decoder #(.P_STABLE_COUNT(1)) dut_b (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (ifb.master)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ca(input logic stb, input logic [6:0] seg,
                      input logic rdy, input int n);
        repeat (n) begin
            ifa.I_STROBE    = stb;
            ifa.I_7_SEGMENT = seg;
            ifa.I_READY     = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cb(input logic stb, input logic [6:0] seg,
                      input logic rdy, input int n);
        repeat (n) begin
            ifb.I_STROBE    = stb;
            ifb.I_7_SEGMENT = seg;
            ifb.I_READY     = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_a(input string tag, input logic v,
                         input logic [3:0] val, input logic e,
                         input logic o);
        chk({tag, ".valid"},   8'(ifa.O_VALID),   8'(v));
        chk({tag, ".value"},   8'(ifa.O_VALUE),   8'(val));
        chk({tag, ".error"},   8'(ifa.O_ERROR),   8'(e));
        chk({tag, ".overrun"}, 8'(ifa.O_OVERRUN), 8'(o));
    endtask

    task automatic chk_b(input string tag, input logic v,
                         input logic [3:0] val, input logic e);
        chk({tag, ".valid"}, 8'(ifb.O_VALID), 8'(v));
        chk({tag, ".value"}, 8'(ifb.O_VALUE), 8'(val));
        chk({tag, ".error"}, 8'(ifb.O_ERROR), 8'(e));
    endtask

    initial begin
        rst = 1'b1;
        ifa.I_STROBE = 1'b0; ifa.I_7_SEGMENT = 7'h7f; ifa.I_READY = 1'b0;
        ifb.I_STROBE = 1'b0; ifb.I_7_SEGMENT = 7'h7f; ifb.I_READY = 1'b0;
        @(posedge clk);
        #1;
        chk_a("reset_a", 1'b0, 4'h0, 1'b0, 1'b0);
        chk_b("reset_b", 1'b0, 4'h0, 1'b0);
        rst = 1'b0;

        // blank bus after reset emits nothing
        ca(1'b1, 7'b1111111, 1'b1, 3);
        chk("blank_after_reset", 8'(ifa.O_VALID), 8'd0);

        // steady 5: one pulse after the 4th strobe
        ca(1'b1, 7'b0010010, 1'b1, 3);
        chk("five_3rd", 8'(ifa.O_VALID), 8'd0);
        ca(1'b1, 7'b0010010, 1'b1, 1);
        chk_a("five_4th", 1'b1, 4'h5, 1'b0, 1'b0);
        ca(1'b1, 7'b0010010, 1'b1, 1);
        chk("five_clear", 8'(ifa.O_VALID), 8'd0);
        ca(1'b1, 7'b0010010, 1'b1, 3);
        chk("five_no_reemit", 8'(ifa.O_VALID), 8'd0);

        // glitch filter
        ca(1'b1, 7'b0001000, 1'b1, 3);
        ca(1'b1, 7'b0000000, 1'b1, 1);
        chk("glitch_8", 8'(ifa.O_VALID), 8'd0);
        ca(1'b1, 7'b0001000, 1'b1, 3);
        chk("glitch_a3", 8'(ifa.O_VALID), 8'd0);
        ca(1'b1, 7'b0001000, 1'b1, 1);
        chk_a("glitch_a4", 1'b1, 4'hA, 1'b0, 1'b0);
        ca(1'b0, 7'b0001000, 1'b1, 1);
        chk("glitch_clear", 8'(ifa.O_VALID), 8'd0);

        // unrecognized then blank
        ca(1'b1, 7'b1111110, 1'b1, 4);
        chk_a("unrec", 1'b1, 4'h0, 1'b1, 1'b0);
        ca(1'b1, 7'b1111111, 1'b1, 4);
        chk("blank_4", 8'(ifa.O_VALID), 8'd0);
        ca(1'b1, 7'b1111111, 1'b1, 4);
        chk("blank_8", 8'(ifa.O_VALID), 8'd0);

        // backpressure
        ca(1'b1, 7'b1111001, 1'b0, 4);
        chk_a("bp_one", 1'b1, 4'h1, 1'b0, 1'b0);
        ca(1'b1, 7'b0001110, 1'b0, 4);
        chk_a("bp_drop_f", 1'b1, 4'h1, 1'b0, 1'b1);
        ca(1'b1, 7'b1111000, 1'b0, 3);
        chk("bp_seven_3", 8'(ifa.O_VALUE), 8'h1);
        ca(1'b1, 7'b1111000, 1'b1, 1);
        chk_a("bp_seven_4", 1'b1, 4'h7, 1'b0, 1'b1);
        ca(1'b0, 7'b1111000, 1'b1, 1);
        chk("bp_clear", 8'(ifa.O_VALID), 8'd0);

        // reset mid-settle with a held word
        ca(1'b1, 7'b0000110, 1'b0, 4);
        chk_a("rst_held_e", 1'b1, 4'hE, 1'b0, 1'b1);
        ca(1'b1, 7'b0100001, 1'b0, 2);
        chk("rst_held_still_e", 8'(ifa.O_VALUE), 8'hE);
        rst = 1'b1;
        ca(1'b0, 7'b0100001, 1'b0, 1);
        chk_a("rst_mid", 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        ca(1'b1, 7'b0100001, 1'b1, 3);
        chk("rst_d_3", 8'(ifa.O_VALID), 8'd0);
        ca(1'b1, 7'b0100001, 1'b1, 1);
        chk_a("rst_d_4", 1'b1, 4'hD, 1'b0, 1'b0);
        ca(1'b0, 7'b0100001, 1'b1, 1);

        // P_STABLE_COUNT = 1: one emit per differing strobe
        cb(1'b1, 7'b1000000, 1'b1, 1);
        chk_b("p1_0a", 1'b1, 4'h0, 1'b0);
        cb(1'b1, 7'b0100100, 1'b1, 1);
        chk_b("p1_2a", 1'b1, 4'h2, 1'b0);
        cb(1'b1, 7'b1000000, 1'b1, 1);
        chk_b("p1_0b", 1'b1, 4'h0, 1'b0);
        cb(1'b1, 7'b0100100, 1'b1, 1);
        chk_b("p1_2b", 1'b1, 4'h2, 1'b0);
        cb(1'b1, 7'b0100100, 1'b1, 1);
        chk("p1_repeat", 8'(ifb.O_VALID), 8'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/seven_segment_hex_decoder.md
# seven_segment_hex_decoder

Recovers hex digits from a sampled, active-low 7-segment bus: the inverse of the hex-to-7-segment mapping used on the board displays. Each new pattern is filtered for stability over a programmable number of strobes, decoded to a 4-bit value or flagged as unrecognized, and emitted once through a valid/ready handshake. The block sits between a segment-bus sampler (loop-back self-test of the display path, or an external display tap) and the CompactRISC16 I/O register file.

## Interface

- P_STABLE_COUNT, 4: consecutive identical strobed samples required to accept a pattern; legal range 1..255.
- I_CLK  input  1  system clock; all state changes on rising edge.
- I_RESET  input  1  synchronous, active-high reset.
- I_STROBE  input  1  I_7_SEGMENT is a valid sample this cycle.
- I_7_SEGMENT  input  7  active-low segments; MSB..LSB = segments 0,1,2,3,4,5,6.
- O_VALID  output  1  decoded digit available; held until accepted.
- I_READY  input  1  consumer accepts the digit when O_VALID && I_READY.
- O_VALUE  output  4  decoded hex digit; 0 when O_ERROR = 1.
- O_ERROR  output  1  qualifies O_VALUE: accepted pattern matched no hex digit.
- O_OVERRUN  output  1  sticky: an accepted digit was dropped because the output was still full.

## Operation

- Pattern table, active-low, MSB = seg 0: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank = 1111111.
- Registers: candidate pattern (7b), stability counter ($clog2(P_STABLE_COUNT+1) bits, saturates), FSM state, output word {O_VALUE, O_ERROR}, O_VALID, O_OVERRUN.
- FSM states:
  - S_SETTLING: on strobe with sample != candidate: candidate <= sample, count <= 1. On strobe with sample == candidate: count <= count+1. The acceptance event fires on the strobe where the count reaches P_STABLE_COUNT (including the loading strobe when P_STABLE_COUNT = 1); state moves to S_LOCKED.
  - S_LOCKED: strobes matching candidate are ignored (no re-emit). A strobe with a differing sample loads candidate, sets count <= 1, and moves to S_SETTLING, or accepts immediately when P_STABLE_COUNT = 1.
- On acceptance: if the pattern is blank, emit nothing. If it is a hex digit, emit {value, 0}. Otherwise emit {0, 1}.
- Emit with the output empty (O_VALID = 0): load the word and set O_VALID.
- Emit while O_VALID && I_READY: the handshake completes and the new word loads in the same cycle; O_VALID stays 1 and no overrun occurs.
- Emit while O_VALID && !I_READY: the new word is dropped, the held word is unchanged, and O_OVERRUN is set.
- O_VALID && I_READY with no emit: O_VALID clears next cycle.
- Cycles without a strobe change no filter state.
- O_OVERRUN clears only on reset.

## Timing

- Reset values: O_VALID=0, O_VALUE=0, O_ERROR=0, O_OVERRUN=0, candidate=1111111 (blank), count=0, state=S_LOCKED. A blank bus after reset therefore produces no output.
- Latency: O_VALID rises on the cycle after the accepting strobe, which is the P_STABLE_COUNT-th consecutive matching strobe.
- O_VALUE and O_ERROR are registered and stable while O_VALID = 1.
- I_READY has no combinational path to any output.
- Reset asserted mid-settle or with O_VALID high: all state returns to reset values at the next edge. The pending word is lost without raising O_OVERRUN.
- The counter saturates at P_STABLE_COUNT and never wraps.

## Structure

- Package seven_segment_pkg holds:
  - the 16 digit pattern localparams and SEG_BLANK;
  - the state enum typedef (S_SETTLING, S_LOCKED);
  - the segment-bit-order constant shared with the mapping module.
- Sub-module seven_segment_hex_unmapping: combinational, pattern[6:0] -> {hit, value[3:0], blank}, implemented as a case over the package constants. It is instantiated once on the candidate register.
- The top level contains the filter counter, the FSM, and the one-entry output buffer.

## Test plan

- P_STABLE_COUNT=4, I_READY=1, strobe 0010010 every cycle: O_VALID pulses once, on the cycle after the 4th strobe, with O_VALUE=5 and O_ERROR=0. No further pulses while the input stays constant.
- Glitch filter: strobes 0001000 x3, 0000000 x1, 0001000 x4: a single emit, O_VALUE=A. Pattern 8 is never emitted.
- Unrecognized pattern 1111110 held for 4 strobes: O_VALID=1, O_ERROR=1, O_VALUE=0. The blank pattern 1111111 held for 8 strobes emits nothing.
- Backpressure: I_READY=0; accept 1 (1111001), then accept F (0001110): O_VALUE stays 1 and O_OVERRUN=1. With I_READY=1 asserted on the same cycle as a new accept of 7 (1111000), the next cycle shows O_VALUE=7, O_VALID=1, and O_OVERRUN unchanged.
- P_STABLE_COUNT=1: alternate strobes 0 and 2 with I_READY=1: one emit per strobe (0, 2, 0, ...), each one cycle after its strobe.
- Reset mid-operation: assert I_RESET after 2 of 4 settling strobes, with O_VALID=1 held: the next cycle shows all outputs at 0. Re-presenting the same pattern then needs 4 full strobes before it emits.
